// File: rtl/pv2long_mem_arb.sv
// Two-port round-robin arbiter sharing one single-ported memory; an in-order tag FIFO routes responses.
// Optional macro PV2LONG_MEM_ARB_FIXED_PRIO_EN: port 1 always wins ties (priority frozen at 1).
module pv2long_mem_arb #(
    parameter int unsigned p_req_msg_sz      = 67,
    parameter int unsigned p_resp_msg_sz     = 35,
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [p_req_msg_sz-1:0]              req0_msg_i,
    input  logic                                 req0_val_i,
    output logic                                 req0_rdy_o,
    input  logic [p_req_msg_sz-1:0]              req1_msg_i,
    input  logic                                 req1_val_i,
    output logic                                 req1_rdy_o,
    output logic [p_req_msg_sz-1:0]              memreq_msg_o,
    output logic                                 memreq_val_o,
    input  logic                                 memreq_rdy_i,
    input  logic [p_resp_msg_sz-1:0]             memresp_msg_i,
    input  logic                                 memresp_val_i,
    output logic [p_resp_msg_sz-1:0]             resp0_msg_o,
    output logic                                 resp0_val_o,
    output logic [p_resp_msg_sz-1:0]             resp1_msg_o,
    output logic                                 resp1_val_o,
    output logic [$clog2(p_max_outstanding):0]   outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned PtrW = $clog2(p_max_outstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic [p_max_outstanding-1:0] tags_q, tags_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              count_q, count_d;
    logic                         err_q, err_d;
    logic                         prio;
    logic                         grant_c, full_c, empty_c, fire_c, pop_c, head_c;

`ifdef PV2LONG_MEM_ARB_FIXED_PRIO_EN
    assign prio = 1'b1;
`else
    logic prio_q, prio_d;
    assign prio = prio_q;

    // The port just served yields priority to the other one.
    always_comb begin
        prio_d = prio_q;
        if (fire_c) begin
            prio_d = ~grant_c;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // Grant: a lone requester wins; a tie goes to the favoured port.
    always_comb begin
        grant_c = req1_val_i;
        if (req0_val_i && req1_val_i) begin
            grant_c = prio;
        end
    end

    assign full_c  = (count_q == CntW'(p_max_outstanding));
    assign empty_c = (count_q == '0);
    assign head_c  = tags_q[rd_ptr_q];

    assign memreq_val_o = reset_n_i & (req0_val_i | req1_val_i) & ~full_c;
    assign memreq_msg_o = grant_c ? req1_msg_i : req0_msg_i;
    assign req0_rdy_o   = memreq_val_o & memreq_rdy_i & req0_val_i & ~grant_c;
    assign req1_rdy_o   = memreq_val_o & memreq_rdy_i & req1_val_i & grant_c;
    assign fire_c       = memreq_val_o & memreq_rdy_i;

    assign pop_c       = reset_n_i & memresp_val_i & ~empty_c;
    assign resp0_val_o = pop_c & ~head_c;
    assign resp1_val_o = pop_c & head_c;
    assign resp0_msg_o = memresp_msg_i;
    assign resp1_msg_o = memresp_msg_i;

    assign outstanding_o = count_q;
    assign err_o         = err_q;

    // Tag FIFO bookkeeping and sticky error on an unmatched response.
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        count_d  = count_q + CntW'(fire_c) - CntW'(pop_c);
        if (fire_c) begin
            tags_d[wr_ptr_q] = grant_c;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (memresp_val_i && empty_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            tags_q   <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule
